move_scheduler: RTL and testbench
=================================

MOVE_SCHEDULER -- requirements
Module: move_scheduler

Interface
REQ-001 SHALL have parameter REPEAT_DELAY, default 25_000_000, meaning hold cycles before first auto-repeat.
REQ-002 SHALL have parameter REPEAT_PERIOD, default 10_000_000, meaning cycles between subsequent auto-repeats.
REQ-003 SHALL have port clk  input  1  sole clock; all logic on posedge clk.
REQ-004 SHALL have port rst  input  1  synchronous active-low reset.
REQ-005 SHALL have port en  input  1  gameplay enable; low suspends command generation.
REQ-006 SHALL have port key_valid  input  1  one-cycle pulse from keyboard decoder marking a key event.
REQ-007 SHALL have port last_change  input  9  {extend, scan code} of the event key.
REQ-008 SHALL have port key_down  input  512  decoder pressed-key vector, indexed by last_change.
REQ-009 SHALL have port move_ready  input  1  game FSM accepts the current move.
REQ-010 SHALL have port move_valid  output  1  a move command is presented.
REQ-011 SHALL have port move_player  output  1  0 = player 1, 1 = player 2.
REQ-012 SHALL have port move_dir  output  2  00 up, 01 left, 10 down, 11 right.

Function
REQ-013 SHALL map P1 codes 0x01D/0x01C/0x01B/0x023 (W/A/S/D) and P2 codes 0x175/0x16B/0x172/0x174 (arrows) to up/left/down/right; all other codes ignored.
REQ-014 SHALL treat a press as key_valid=1, mapped code, key_down[last_change]=1; a release is the same with key_down[last_change]=0.
REQ-015 SHALL keep one pending slot per player (pend_vld, pend_dir); a press sets pend_vld and overwrites pend_dir (latest wins).
REQ-016 SHALL hold an output register; move_valid, move_player and move_dir SHALL stay stable while move_valid=1 and move_ready=0.
REQ-017 SHALL complete a transfer on a clock edge with move_valid=1 and move_ready=1.
REQ-018 SHALL load the output register from a pending slot when it is empty or transferring in that cycle, giving at most one move per cycle (back-to-back allowed).
REQ-019 SHALL arbitrate round-robin when both slots are pending: grant the player not granted last; pointer updates only on load.
REQ-020 SHALL clear the granted pend_vld on load, unless a press for that player arrives the same cycle, in which case the slot keeps the new direction with pend_vld=1.
REQ-021 SHALL assert move_valid at the second rising edge after the key_valid cycle when the output is empty and the other slot is idle.
REQ-022 SHALL run, per player, a hold FSM with states IDLE, DELAY, REPEAT and a 24-bit counter.
REQ-023 SHALL, on a press, enter DELAY with counter 0 and hold_dir = pressed direction, from any state.
REQ-024 SHALL, in DELAY, on counter = REPEAT_DELAY-1 set the pending slot with hold_dir, enter REPEAT and clear the counter; otherwise increment.
REQ-025 SHALL, in REPEAT, on counter = REPEAT_PERIOD-1 set the pending slot with hold_dir and clear the counter; otherwise increment.
REQ-026 SHALL return to IDLE on release of the key matching hold_dir; releases of other keys of that player SHALL be ignored.
REQ-027 SHALL leave an already-valid pending slot unchanged on an auto-repeat injection; repeats never queue beyond one.
REQ-028 SHALL, while en=0, ignore presses, force both hold FSMs to IDLE, and clear both pend_vld; an output already presented SHALL still complete its handshake.

Reset
REQ-029 SHALL, on a rising edge with rst=0, clear move_valid, move_player, move_dir, both pending slots and both counters; hold FSMs to IDLE; round-robin pointer favours player 1.
REQ-030 SHALL abandon any presented move on reset mid-handshake, with no transfer counted.

Configuration
REQ-031 SHALL, with AUTOREPEAT_EN defined, implement the hold FSMs and counters per REQ-022..REQ-027.
REQ-032 SHALL, without AUTOREPEAT_EN, omit hold FSMs and counters; moves come only from presses, ignore REPEAT_* parameters, and leave all other behaviour identical.

Verification
REQ-033 SHALL cover: P1 'W' press, move_ready=1 -> move_valid at the second edge for one cycle, player 0, dir 00.
REQ-034 SHALL cover: P1 'D' then P2 right-arrow on consecutive cycles, move_ready=0 for 10 cycles then 1 -> P1/11 then P2/11, with outputs stable while stalled.
REQ-035 SHALL cover: both slots pending for three rounds, move_ready=1 -> grants alternate P1, P2, P1.
REQ-036 SHALL cover: AUTOREPEAT_EN, REPEAT_DELAY=8, REPEAT_PERIOD=4, 'S' held 20 cycles, move_ready=1 -> moves at press+2, +10, +14, +18; none after release.
REQ-037 SHALL cover: en=0 during a held 'A' with move_valid=1 and move_ready=0 -> the pending move completes on ready, and no further moves follow.
REQ-038 SHALL cover: rst=0 while move_valid=1 -> all outputs 0 at the next edge, and arbitration restarts at player 1.

Source files
------------

// File: rtl/move_scheduler.sv
// move_scheduler
//
// Turns keyboard decoder events into a stream of move commands for the game
// FSM. Each player owns a one-deep pending slot. Pending slots feed a single
// output register through a round-robin arbiter. The output register uses a
// valid/ready handshake.
//
// Optional feature: define AUTOREPEAT_EN to add a per-player hold FSM. A held
// key then re-injects its direction after REPEAT_DELAY cycles, and again every
// REPEAT_PERIOD cycles after that. Without the macro, moves come only from
// presses and the REPEAT_* parameters have no effect.
//
// Ports
//   clk          sole clock, all logic on the rising edge
//   rst          synchronous reset, active low
//   en           gameplay enable; low drops presses, holds and pending moves
//   key_valid    one-cycle strobe marking a decoder key event
//   last_change  {extend, scan code} of the event key
//   key_down     decoder pressed-key vector, indexed by last_change
//   move_ready   game FSM accepts the presented move
//   move_valid   a move command is presented
//   move_player  0 = player 1, 1 = player 2
//   move_dir     00 up, 01 left, 10 down, 11 right

module move_scheduler #(
   parameter int REPEAT_DELAY  = 25_000_000,
   parameter int REPEAT_PERIOD = 10_000_000
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         en,
   input  logic         key_valid,
   input  logic [8:0]   last_change,
   input  logic [511:0] key_down,
   input  logic         move_ready,
   output logic         move_valid,
   output logic         move_player,
   output logic [1:0]   move_dir
);

   // ---------------- key decode ----------------
   logic       key_hit;
   logic       key_player;
   logic [1:0] key_dir;
   logic       key_level;
   logic       press_any;

   always_comb begin
      key_hit    = 1'b1;
      key_player = 1'b0;
      key_dir    = 2'b00;
      case (last_change)
         9'h01D: begin key_player = 1'b0; key_dir = 2'b00; end
         9'h01C: begin key_player = 1'b0; key_dir = 2'b01; end
         9'h01B: begin key_player = 1'b0; key_dir = 2'b10; end
         9'h023: begin key_player = 1'b0; key_dir = 2'b11; end
         9'h175: begin key_player = 1'b1; key_dir = 2'b00; end
         9'h16B: begin key_player = 1'b1; key_dir = 2'b01; end
         9'h172: begin key_player = 1'b1; key_dir = 2'b10; end
         9'h174: begin key_player = 1'b1; key_dir = 2'b11; end
         default: key_hit = 1'b0;
      endcase
   end

   assign key_level = key_down[last_change];
   assign press_any = en & key_valid & key_hit & key_level;

`ifdef AUTOREPEAT_EN
   typedef enum logic [1:0] {ST_IDLE, ST_DELAY, ST_REPEAT} hold_state_t;

   // The counter is nominally 24 bits wide. It widens automatically so that
   // the default REPEAT_DELAY (which exceeds 2^24) remains reachable.
   localparam int CNT_W_D = ($clog2(REPEAT_DELAY) > 24) ? $clog2(REPEAT_DELAY) : 24;
   localparam int CNT_W   = ($clog2(REPEAT_PERIOD) > CNT_W_D) ? $clog2(REPEAT_PERIOD) : CNT_W_D;
   localparam logic [CNT_W-1:0] DELAY_LAST  = CNT_W'(REPEAT_DELAY - 1);
   localparam logic [CNT_W-1:0] PERIOD_LAST = CNT_W'(REPEAT_PERIOD - 1);

   logic release_any;
   assign release_any = en & key_valid & key_hit & ~key_level;
`endif

   // ---------------- arbitration and output register ----------------
   logic [1:0] pend_vld;
   logic [1:0] pend_dir [2];
   logic       out_free;
   logic       load;
   logic       grant_player;
   logic [1:0] grant_dir;

   logic       out_vld_q, out_vld_d;
   logic       out_player_q, out_player_d;
   logic [1:0] out_dir_q, out_dir_d;
   logic       last_q, last_d;   // player granted most recently

   // The output can accept a new move when it is empty or transferring now.
   assign out_free = ~out_vld_q | move_ready;

   always_comb begin
      load         = en & out_free & (|pend_vld);
      grant_player = (pend_vld[0] & pend_vld[1]) ? ~last_q : pend_vld[1];
      grant_dir    = pend_dir[grant_player];

      out_vld_d    = out_vld_q & ~move_ready;
      out_player_d = out_player_q;
      out_dir_d    = out_dir_q;
      last_d       = last_q;
      if (load) begin
         out_vld_d    = 1'b1;
         out_player_d = grant_player;
         out_dir_d    = grant_dir;
         last_d       = grant_player;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         out_vld_q    <= 1'b0;
         out_player_q <= 1'b0;
         out_dir_q    <= 2'b00;
         last_q       <= 1'b1;   // so player 1 wins the first contested grant
      end else begin
         out_vld_q    <= out_vld_d;
         out_player_q <= out_player_d;
         out_dir_q    <= out_dir_d;
         last_q       <= last_d;
      end
   end

   assign move_valid  = out_vld_q;
   assign move_player = out_player_q;
   assign move_dir    = out_dir_q;

   // ---------------- per-player pending slot and hold FSM ----------------
   for (genvar gi = 0; gi < 2; gi++) begin : g_player
      localparam logic PID = 1'(gi);

      logic       my_press;
      logic       inject;
      logic [1:0] inj_dir;
      logic       pend_vld_q, pend_vld_d;
      logic [1:0] pend_dir_q, pend_dir_d;

      assign my_press = press_any & (key_player == PID);

`ifdef AUTOREPEAT_EN
      hold_state_t      state_q, state_d;
      logic [CNT_W-1:0] cnt_q, cnt_d;
      logic [1:0]       hold_dir_q, hold_dir_d;
      logic             my_release;

      assign my_release = release_any & (key_player == PID);
      assign inj_dir    = hold_dir_q;

      always_comb begin
         state_d    = state_q;
         cnt_d      = cnt_q;
         hold_dir_d = hold_dir_q;
         inject     = 1'b0;
         case (state_q)
            ST_DELAY: begin
               if (cnt_q == DELAY_LAST) begin
                  inject  = 1'b1;
                  state_d = ST_REPEAT;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end
            ST_REPEAT: begin
               if (cnt_q == PERIOD_LAST) begin
                  inject = 1'b1;
                  cnt_d  = '0;
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end
            default: state_d = ST_IDLE;
         endcase
         // Only releasing the key being held stops the repeat.
         if (my_release && (key_dir == hold_dir_q)) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
            inject  = 1'b0;
         end
         if (my_press) begin
            state_d    = ST_DELAY;
            cnt_d      = '0;
            hold_dir_d = key_dir;
            inject     = 1'b0;
         end
         if (!en) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
            inject  = 1'b0;
         end
      end

      always_ff @(posedge clk) begin
         if (!rst) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            hold_dir_q <= 2'b00;
         end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            hold_dir_q <= hold_dir_d;
         end
      end
`else
      assign inject  = 1'b0;
      assign inj_dir = 2'b00;
`endif

      always_comb begin
         pend_vld_d = pend_vld_q & ~(load & (grant_player == PID));
         pend_dir_d = pend_dir_q;
         // A repeat lands only in a slot that is empty after this cycle's load.
         if (inject && !pend_vld_d) begin
            pend_vld_d = 1'b1;
            pend_dir_d = inj_dir;
         end
         // A fresh press always wins, even over a load from this slot.
         if (my_press) begin
            pend_vld_d = 1'b1;
            pend_dir_d = key_dir;
         end
         if (!en) begin
            pend_vld_d = 1'b0;
         end
      end

      always_ff @(posedge clk) begin
         if (!rst) begin
            pend_vld_q <= 1'b0;
            pend_dir_q <= 2'b00;
         end else begin
            pend_vld_q <= pend_vld_d;
            pend_dir_q <= pend_dir_d;
         end
      end

      assign pend_vld[gi] = pend_vld_q;
      assign pend_dir[gi] = pend_dir_q;
   end

endmodule

// File: tb/tb_move_scheduler.sv
// Bench for move_scheduler. The bench pushes each expected move, together with
// the cycle at which it should first appear, onto a queue. A negedge monitor
// pops the queue on every transfer and also checks that the outputs stay
// stable while the move is stalled.
module tb_move_scheduler;

   logic         clk;
   logic         rst;
   logic         en;
   logic         key_valid;
   logic [8:0]   last_change;
   logic [511:0] key_down;
   logic         move_ready;
   logic         move_valid;
   logic         move_player;
   logic [1:0]   move_dir;

   localparam logic [8:0] K_W     = 9'h01D;
   localparam logic [8:0] K_A     = 9'h01C;
   localparam logic [8:0] K_S     = 9'h01B;
   localparam logic [8:0] K_D     = 9'h023;
   localparam logic [8:0] K_UP    = 9'h175;
   localparam logic [8:0] K_LEFT  = 9'h16B;
   localparam logic [8:0] K_DOWN  = 9'h172;
   localparam logic [8:0] K_RIGHT = 9'h174;

   typedef struct {
      logic       player;
      logic [1:0] dir;
      int         cyc;     // cycle of first presentation, -1 = don't care
   } exp_t;

   exp_t sb_q[$];
   int   n_assert = 0;
   int   n_fail   = 0;
   int   cyc      = 0;

   move_scheduler #(
      .REPEAT_DELAY (8),
      .REPEAT_PERIOD(4)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .en         (en),
      .key_valid  (key_valid),
      .last_change(last_change),
      .key_down   (key_down),
      .move_ready (move_ready),
      .move_valid (move_valid),
      .move_player(move_player),
      .move_dir   (move_dir)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      forever begin
         @(posedge clk);
         cyc++;
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push_exp(input logic p, input logic [1:0] d, input int c);
      exp_t e;
      e.player = p;
      e.dir    = d;
      e.cyc    = c;
      sb_q.push_back(e);
   endtask

   task automatic key_event(input logic [8:0] code, input logic down, output int at);
      at                = cyc;
      key_valid         = 1'b1;
      last_change       = code;
      key_down[code]    = down;
      tick();
      key_valid         = 1'b0;
   endtask

   task automatic wait_drain(input int budget, input string tag);
      for (int i = 0; i < budget && sb_q.size() != 0; i++) tick();
      check(tag, sb_q.size(), 0);
   endtask

   // Transfer monitor: compares each completed handshake with the queue head.
   initial begin
      logic       first_seen;
      logic       stall_prev;
      logic [2:0] stall_val;
      int         pres_cyc;
      exp_t       e;
      first_seen = 1'b0;
      stall_prev = 1'b0;
      stall_val  = 3'b000;
      pres_cyc   = 0;
      forever begin
         @(negedge clk);
         if (rst === 1'b1 && move_valid === 1'b1) begin
            if (!first_seen) begin
               first_seen = 1'b1;
               pres_cyc   = cyc;
            end
            if (stall_prev) check("stall_stable", {move_player, move_dir}, stall_val);
            if (move_ready === 1'b1) begin
               check("unexpected_move", sb_q.size() > 0, 1);
               if (sb_q.size() > 0) begin
                  e = sb_q.pop_front();
                  check("move_data", {move_player, move_dir}, {e.player, e.dir});
                  if (e.cyc >= 0) check("move_cycle", pres_cyc, e.cyc);
               end
               first_seen = 1'b0;
               stall_prev = 1'b0;
            end else begin
               stall_prev = 1'b1;
               stall_val  = {move_player, move_dir};
            end
         end else begin
            first_seen = 1'b0;
            stall_prev = 1'b0;
         end
      end
   end

   initial begin
      int k, kx, r;
      rst         = 1'b0;
      en          = 1'b1;
      key_valid   = 1'b0;
      last_change = 9'h000;
      key_down    = '0;
      move_ready  = 1'b0;
      repeat (3) tick();
      check("rst_valid", move_valid, 0);
      check("rst_player", move_player, 0);
      check("rst_dir", move_dir, 0);
      rst = 1'b1;
      tick();

      // Single W press: presented at the second edge, accepted at once.
      move_ready = 1'b1;
      key_event(K_W, 1'b1, k);
      push_exp(1'b0, 2'b00, k + 2);
      key_event(K_W, 1'b0, kx);
      wait_drain(10, "drain_w");
      repeat (5) tick();

      // D then right-arrow under a 10-cycle stall, then back-to-back.
      move_ready = 1'b0;
      key_event(K_D, 1'b1, k);
      push_exp(1'b0, 2'b11, k + 2);
      key_event(K_RIGHT, 1'b1, kx);
      key_event(K_D, 1'b0, kx);
      key_event(K_RIGHT, 1'b0, kx);
      repeat (8) tick();
      check("stall_valid", move_valid, 1);
      repeat (2) tick();
      r = cyc;
      push_exp(1'b1, 2'b11, r + 1);
      move_ready = 1'b1;
      wait_drain(10, "drain_stall");
      repeat (3) tick();

      // Both slots pending: round-robin gives P1, P2, P1.
      move_ready = 1'b0;
      key_event(K_W, 1'b1, k);
      push_exp(1'b0, 2'b00, k + 2);
      key_event(K_UP, 1'b1, kx);
      key_event(K_A, 1'b1, kx);
      key_event(K_DOWN, 1'b1, kx);
      key_event(K_W, 1'b0, kx);
      key_event(K_UP, 1'b0, kx);
      key_event(K_A, 1'b0, kx);
      key_event(K_DOWN, 1'b0, kx);
      r = cyc;
      push_exp(1'b1, 2'b10, r + 1);
      push_exp(1'b0, 2'b01, r + 2);
      move_ready = 1'b1;
      wait_drain(10, "drain_rr");
      repeat (3) tick();

      // Held S for 20 key cycles with ready high.
      key_event(K_S, 1'b1, k);
      push_exp(1'b0, 2'b10, k + 2);
`ifdef AUTOREPEAT_EN
      push_exp(1'b0, 2'b10, k + 10);
      push_exp(1'b0, 2'b10, k + 14);
      push_exp(1'b0, 2'b10, k + 18);
`endif
      while (cyc < k + 19) tick();
      key_event(K_S, 1'b0, kx);
      check("hold_drained", sb_q.size(), 0);
      repeat (30) tick();

      // en drops while A is held and its move is stalled.
      move_ready = 1'b0;
      key_event(K_A, 1'b1, k);
      push_exp(1'b0, 2'b01, k + 2);
      tick();
      check("en_stall_valid", move_valid, 1);
      en = 1'b0;
      repeat (12) tick();
      check("en_still_valid", move_valid, 1);
      move_ready = 1'b1;
      wait_drain(5, "drain_en");
      repeat (30) tick();
      en = 1'b1;
      key_event(K_A, 1'b0, kx);
      repeat (5) tick();

      // Reset while a move is presented and another is pending.
      move_ready = 1'b0;
      key_event(K_UP, 1'b1, k);
      key_event(K_W, 1'b1, kx);
      key_event(K_UP, 1'b0, kx);
      key_event(K_W, 1'b0, kx);
      check("pre_rst_valid", move_valid, 1);
      check("pre_rst_player", move_player, 1);
      rst = 1'b0;
      tick();
      check("mid_rst_valid", move_valid, 0);
      check("mid_rst_player", move_player, 0);
      check("mid_rst_dir", move_dir, 0);
      rst = 1'b1;
      move_ready = 1'b1;
      repeat (10) tick();
      move_ready = 1'b0;
      key_event(K_A, 1'b1, k);
      push_exp(1'b0, 2'b01, k + 2);
      key_event(K_LEFT, 1'b1, kx);
      key_event(K_A, 1'b0, kx);
      key_event(K_LEFT, 1'b0, kx);
      r = cyc;
      push_exp(1'b1, 2'b01, r + 1);
      move_ready = 1'b1;
      wait_drain(10, "drain_post_rst");
      repeat (5) tick();

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
